ltc2195_frame_aligner: RTL and testbench

Link-training controller for the LTC2195 receiver. It consumes the 4-bit deserialized frame word. It drives the receiver's ISERDES bitslip strobe and the IDELAY tap value until the frame word equals the expected pattern, then monitors lock. It runs entirely in the DCO_2D (divided ADC clock) domain, directly beside the receiver, and reports status to the control/CSR logic.

---
 rtl/ltc2195_frame_aligner.sv | 195 +++++++++++++++++++
 tb/tb_ltc2195_frame_aligner.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ltc2195_frame_aligner.sv
// Frame-word alignment controller for the LTC2195 LVDS receiver: walks bitslip and
// IDELAY taps until the frame word matches, then watches for loss of lock.
module ltc2195_frame_aligner #(
  parameter logic [3:0] FRAME_PATTERN = 4'b1100,
  parameter int         INIT_DELAY    = 0,
  parameter int         DELAY_STEP    = 4,
  parameter int         SETTLE_CYCLES = 8,
  parameter int         CHECK_CYCLES  = 16,
  parameter int         LOSS_THRESH   = 4,
  parameter bit         AUTO_RELOCK   = 1'b1
) (
  input  logic       DCO_2D,
  input  logic       rst_n_in,
  input  logic       start,
  input  logic [3:0] FR_in,
  input  logic       idelay_rdy,
  output logic       bitslip,
  output logic [4:0] delay_val,
  output logic       aligned,
  output logic       busy,
  output logic       fail,
  output logic [1:0] slip_cnt,
  output logic [7:0] relock_cnt
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_RDY = 3'd1;
  localparam logic [2:0] S_SETTLE   = 3'd2;
  localparam logic [2:0] S_CHECK    = 3'd3;
  localparam logic [2:0] S_SLIP     = 3'd4;
  localparam logic [2:0] S_NEXT_TAP = 3'd5;
  localparam logic [2:0] S_LOCKED   = 3'd6;
  localparam logic [2:0] S_FAIL     = 3'd7;

  localparam int             CW        = 16;
  localparam logic [CW-1:0]  SETTLE_LD = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0]  CHECK_LD  = CW'(CHECK_CYCLES);
  localparam logic [CW-1:0]  LOSS_LD   = CW'(LOSS_THRESH);
  localparam logic [4:0]     INIT_TAP  = 5'(INIT_DELAY);
  localparam logic [4:0]     STEP5     = 5'(DELAY_STEP);
  localparam logic [5:0]     STEP6     = 6'(DELAY_STEP);

  logic [2:0]    state_r, state_s;
  logic [4:0]    delay_r, delay_s;
  logic [1:0]    slip_r, slip_s;
  logic [CW-1:0] settle_r, settle_s;
  logic [CW-1:0] match_r, match_s;
  logic [CW-1:0] miss_r, miss_s;
  logic [7:0]    relock_r, relock_s;
  logic          bitslip_r, aligned_r, busy_r, fail_r;
  logic          frame_ok_s, tap_over_s;

  assign frame_ok_s = (FR_in == FRAME_PATTERN);
  // Six-bit sum so a step past tap 31 is detected instead of wrapping.
  assign tap_over_s = (({1'b0, delay_r} + STEP6) > 6'd31);

  // Next-state and datapath decisions; every output is a registered decode of state_s.
  always_comb begin
    state_s  = state_r;
    delay_s  = delay_r;
    slip_s   = slip_r;
    settle_s = settle_r;
    match_s  = match_r;
    miss_s   = miss_r;
    relock_s = relock_r;
    case (state_r)
      S_IDLE, S_FAIL: begin
        if (start) begin
          delay_s = INIT_TAP;
          slip_s  = 2'd0;
          state_s = S_WAIT_RDY;
        end else begin
          state_s = state_r;
        end
      end
      S_WAIT_RDY: begin
        if (idelay_rdy) begin
          settle_s = SETTLE_LD;
          state_s  = S_SETTLE;
        end else begin
          state_s = S_WAIT_RDY;
        end
      end
      S_SETTLE: begin
        if (!idelay_rdy) begin
          state_s = S_WAIT_RDY;
        end else if (settle_r == '0) begin
          match_s = '0;
          state_s = S_CHECK;
        end else begin
          settle_s = settle_r - 16'd1;
        end
      end
      S_CHECK: begin
        if (!idelay_rdy) begin
          state_s = S_WAIT_RDY;
        end else if (frame_ok_s) begin
          if (match_r + 16'd1 == CHECK_LD) begin
            miss_s  = '0;
            state_s = S_LOCKED;
          end else begin
            match_s = match_r + 16'd1;
          end
        end else if (slip_r == 2'd3) begin
          state_s = S_NEXT_TAP;
        end else begin
          state_s = S_SLIP;
        end
      end
      S_SLIP: begin
        slip_s   = slip_r + 2'd1;
        settle_s = SETTLE_LD;
        state_s  = idelay_rdy ? S_SETTLE : S_WAIT_RDY;
      end
      S_NEXT_TAP: begin
        // The ISERDES slip position carries over; four slips bring it back to origin.
        if (tap_over_s) begin
          state_s = idelay_rdy ? S_FAIL : S_WAIT_RDY;
        end else begin
          delay_s  = delay_r + STEP5;
          slip_s   = 2'd0;
          settle_s = SETTLE_LD;
          state_s  = idelay_rdy ? S_SETTLE : S_WAIT_RDY;
        end
      end
      S_LOCKED: begin
        if (frame_ok_s) begin
          miss_s = '0;
        end else if (miss_r + 16'd1 == LOSS_LD) begin
          miss_s   = '0;
          relock_s = (relock_r == 8'd255) ? relock_r : relock_r + 8'd1;
          if (AUTO_RELOCK) begin
            delay_s = INIT_TAP;
            slip_s  = 2'd0;
            state_s = S_WAIT_RDY;
          end else begin
            state_s = S_IDLE;
          end
        end else begin
          miss_s = miss_r + 16'd1;
        end
        // A restart request overrides the loss outcome but the loss is still counted.
        if (start) begin
          delay_s = INIT_TAP;
          slip_s  = 2'd0;
          state_s = S_WAIT_RDY;
        end else begin
          state_s = state_s;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State, counters and registered output decode.
  always_ff @(posedge DCO_2D or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r   <= S_IDLE;
      delay_r   <= INIT_TAP;
      slip_r    <= 2'd0;
      settle_r  <= '0;
      match_r   <= '0;
      miss_r    <= '0;
      relock_r  <= 8'd0;
      bitslip_r <= 1'b0;
      aligned_r <= 1'b0;
      busy_r    <= 1'b0;
      fail_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      delay_r   <= delay_s;
      slip_r    <= slip_s;
      settle_r  <= settle_s;
      match_r   <= match_s;
      miss_r    <= miss_s;
      relock_r  <= relock_s;
      bitslip_r <= (state_s == S_SLIP);
      aligned_r <= (state_s == S_LOCKED);
      busy_r    <= (state_s == S_WAIT_RDY) || (state_s == S_SETTLE) || (state_s == S_CHECK) ||
                   (state_s == S_SLIP) || (state_s == S_NEXT_TAP);
      fail_r    <= (state_s == S_FAIL);
    end
  end

  assign bitslip    = bitslip_r;
  assign delay_val  = delay_r;
  assign aligned    = aligned_r;
  assign busy       = busy_r;
  assign fail       = fail_r;
  assign slip_cnt   = slip_r;
  assign relock_cnt = relock_r;

endmodule

// File: tb/tb_ltc2195_frame_aligner.sv
// Bench for ltc2195_frame_aligner: emulated receiver (rotating frame word, tap window),
// behavioural model compared every cycle, plus directed literal checks.
module tb_ltc2195_frame_aligner;

  localparam logic [3:0] PAT    = 4'b1100;
  localparam int         SETTLE = 8;
  localparam int         CHECKN = 16;
  localparam int         LOSS   = 4;
  localparam int         STEP   = 4;
  localparam int         INIT   = 0;

  localparam int M_IDLE = 0, M_WAIT = 1, M_SETTLE = 2, M_CHECK = 3;
  localparam int M_SLIP = 4, M_STEP = 5, M_LOCKED = 6, M_FAIL = 7;

  logic       DCO_2D = 1'b0;
  logic       rst_n_in = 1'b0;
  logic       start = 1'b0;
  logic [3:0] FR_in = 4'b0000;
  logic       idelay_rdy = 1'b1;

  logic       bitslip, aligned, busy, fail;
  logic [4:0] delay_val;
  logic [1:0] slip_cnt;
  logic [7:0] relock_cnt;
  logic       bitslip2, aligned2, busy2, fail2;
  logic [4:0] delay_val2;
  logic [1:0] slip_cnt2;
  logic [7:0] relock_cnt2;

  ltc2195_frame_aligner dut (
    .DCO_2D(DCO_2D), .rst_n_in(rst_n_in), .start(start), .FR_in(FR_in), .idelay_rdy(idelay_rdy),
    .bitslip(bitslip), .delay_val(delay_val), .aligned(aligned), .busy(busy), .fail(fail),
    .slip_cnt(slip_cnt), .relock_cnt(relock_cnt)
  );

  ltc2195_frame_aligner #(.AUTO_RELOCK(1'b0)) dut2 (
    .DCO_2D(DCO_2D), .rst_n_in(rst_n_in), .start(start), .FR_in(FR_in), .idelay_rdy(idelay_rdy),
    .bitslip(bitslip2), .delay_val(delay_val2), .aligned(aligned2), .busy(busy2), .fail(fail2),
    .slip_cnt(slip_cnt2), .relock_cnt(relock_cnt2)
  );

  always #5 DCO_2D = ~DCO_2D;

  typedef struct packed {
    int mode;
    int settle_t;
    int hits;
    int misses;
    int tap;
    int slips;
    int relocks;
  } mdl_t;

  mdl_t m1, m2;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.mode = M_IDLE; r.settle_t = 0; r.hits = 0; r.misses = 0;
    r.tap = INIT; r.slips = 0; r.relocks = 0;
    return r;
  endfunction

  // One clock of the aligner as described in prose: time spent settling counts up,
  // a window of CHECKN consecutive good words locks, LOSS consecutive bad ones unlocks.
  function automatic mdl_t mdl_next(input mdl_t s, input logic st, input logic [3:0] fr,
                                    input logic rdy, input bit auto_rl);
    mdl_t n = s;
    bit ok = (fr == PAT);
    if (s.mode == M_IDLE || s.mode == M_FAIL) begin
      if (st) begin n.mode = M_WAIT; n.tap = INIT; n.slips = 0; end
    end else if (s.mode == M_LOCKED) begin
      n.misses = ok ? 0 : s.misses + 1;
      if (n.misses == LOSS) begin
        n.misses = 0;
        n.relocks = (s.relocks < 255) ? s.relocks + 1 : 255;
        if (auto_rl) begin n.mode = M_WAIT; n.tap = INIT; n.slips = 0; end
        else n.mode = M_IDLE;
      end
      if (st) begin n.mode = M_WAIT; n.tap = INIT; n.slips = 0; end
    end else if (s.mode == M_WAIT) begin
      if (rdy) begin n.mode = M_SETTLE; n.settle_t = 0; end
    end else if (!rdy) begin
      n.mode = M_WAIT;
      if (s.mode == M_SLIP) n.slips = s.slips + 1;
      if (s.mode == M_STEP && s.tap + STEP <= 31) begin n.tap = s.tap + STEP; n.slips = 0; end
    end else if (s.mode == M_SETTLE) begin
      if (s.settle_t == SETTLE) begin n.mode = M_CHECK; n.hits = 0; end
      else n.settle_t = s.settle_t + 1;
    end else if (s.mode == M_CHECK) begin
      if (ok) begin
        n.hits = s.hits + 1;
        if (n.hits == CHECKN) begin n.mode = M_LOCKED; n.misses = 0; end
      end else begin
        n.mode = (s.slips == 3) ? M_STEP : M_SLIP;
      end
    end else if (s.mode == M_SLIP) begin
      n.slips = s.slips + 1; n.mode = M_SETTLE; n.settle_t = 0;
    end else begin
      if (s.tap + STEP > 31) n.mode = M_FAIL;
      else begin n.tap = s.tap + STEP; n.slips = 0; n.mode = M_SETTLE; n.settle_t = 0; end
    end
    return n;
  endfunction

  // Reference model advances on the same edges as the DUTs.
  always @(posedge DCO_2D or negedge rst_n_in) begin
    if (!rst_n_in) begin
      m1 <= mdl_reset();
      m2 <= mdl_reset();
    end else begin
      m1 <= mdl_next(m1, start, FR_in, idelay_rdy, 1'b1);
      m2 <= mdl_next(m2, start, FR_in, idelay_rdy, 1'b0);
    end
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Receiver emulation state.
  logic [3:0] base = PAT;
  int  slip_pos = 0;
  int  win_lo = 0;
  int  win_hi = 31;
  bit  noise_rand = 1'b0;
  int  inj_left = 0;
  int  pulse_cnt = 0;
  int  pulses_at[32];
  int  last_pulse = -1;
  int  min_gap = 1000;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] rotl(input logic [3:0] w, input int n);
    logic [3:0] r = w;
    for (int i = 0; i < (n % 4); i++) r = {r[2:0], r[3]};
    return r;
  endfunction

  task automatic cmp_model(input string tag, input mdl_t m, input logic bs, input logic [4:0] dv,
                           input logic al, input logic bz, input logic fl, input logic [1:0] sc,
                           input logic [7:0] rc);
    chk({tag, "_bitslip"}, int'(bs), int'(m.mode == M_SLIP));
    chk({tag, "_delay_val"}, int'(dv), m.tap);
    chk({tag, "_aligned"}, int'(al), int'(m.mode == M_LOCKED));
    chk({tag, "_busy"}, int'(bz), int'(m.mode >= M_WAIT && m.mode <= M_STEP));
    chk({tag, "_fail"}, int'(fl), int'(m.mode == M_FAIL));
    chk({tag, "_slip_cnt"}, int'(sc), m.slips);
    chk({tag, "_relock_cnt"}, int'(rc), m.relocks);
  endtask

  // One cycle: compare both DUTs to the model at the falling edge, then let the
  // emulated receiver react to the strobe/tap and present the next frame word.
  task automatic tick();
    @(negedge DCO_2D);
    cyc++;
    cmp_model("m1", m1, bitslip, delay_val, aligned, busy, fail, slip_cnt, relock_cnt);
    cmp_model("m2", m2, bitslip2, delay_val2, aligned2, busy2, fail2, slip_cnt2, relock_cnt2);
    if (bitslip) begin
      slip_pos++;
      pulse_cnt++;
      pulses_at[delay_val]++;
      if (last_pulse >= 0 && cyc - last_pulse < min_gap) min_gap = cyc - last_pulse;
      last_pulse = cyc;
    end
    if (inj_left > 0) begin
      inj_left--;
      FR_in = 4'b0011;
    end else if (int'(delay_val) >= win_lo && int'(delay_val) <= win_hi) begin
      FR_in = rotl(base, slip_pos);
    end else begin
      FR_in = noise_rand ? 4'($urandom_range(0, 15)) : 4'b1111;
    end
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_stats();
    pulse_cnt = 0;
    last_pulse = -1;
    min_gap = 1000;
    for (int i = 0; i < 32; i++) pulses_at[i] = 0;
  endtask

  task automatic wait_aligned(input string nm, input int limit);
    int n = 0;
    while (!aligned && n < limit) begin
      tick();
      n++;
    end
    chk({nm, "_lock_reached"}, int'(aligned), 1);
  endtask

  initial begin
    int t0;
    int n;
    int rdy_hold;
    clear_stats();

    // Reset values
    tick(); tick();
    chk("rst_bitslip", int'(bitslip), 0);
    chk("rst_delay_val", int'(delay_val), 0);
    chk("rst_aligned", int'(aligned), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_fail", int'(fail), 0);
    chk("rst_relock_cnt", int'(relock_cnt), 0);
    rst_n_in = 1'b1;
    tick(); tick();

    // Already aligned: no slips, lock after 1 + (SETTLE+1) + CHECKN edges
    base = PAT; slip_pos = 0; clear_stats();
    start_pulse();
    t0 = cyc;
    wait_aligned("direct", 60);
    chk("direct_latency", cyc - t0, 26);
    chk("direct_busy_at_lock", int'(busy), 0);
    chk("direct_pulses", pulse_cnt, 0);
    chk("direct_delay_val", int'(delay_val), 0);

    // Three mismatches then a match keep lock; four in a row drop it
    inj_left = 3;
    repeat (6) tick();
    chk("loss3_aligned", int'(aligned), 1);
    chk("loss3_aligned2", int'(aligned2), 1);
    inj_left = 4;
    repeat (4) tick();
    chk("loss4_before_edge", int'(aligned), 1);
    tick();
    chk("loss4_aligned", int'(aligned), 0);
    chk("loss4_relock_cnt", int'(relock_cnt), 1);
    chk("loss4_busy", int'(busy), 1);
    chk("loss4_norelock_busy", int'(busy2), 0);
    chk("loss4_norelock_aligned", int'(aligned2), 0);
    chk("loss4_norelock_relock_cnt", int'(relock_cnt2), 1);
    wait_aligned("relock", 80);
    chk("relock_delay_val", int'(delay_val), 0);

    // One slip needed
    base = 4'b0110; slip_pos = 0; clear_stats();
    start_pulse();
    wait_aligned("slip1", 200);
    chk("slip1_pulses", pulse_cnt, 1);
    chk("slip1_slip_cnt", int'(slip_cnt), 1);
    chk("slip1_delay_val", int'(delay_val), 0);

    // Two slips needed, spaced by at least a full settle
    base = 4'b0011; slip_pos = 0; clear_stats();
    start_pulse();
    wait_aligned("slip2", 200);
    chk("slip2_pulses", pulse_cnt, 2);
    chk("slip2_gap_ok", int'(min_gap >= SETTLE + 1), 1);

    // Eye only open from tap 12: three slips at taps 0, 4, 8, then lock at 12
    base = 4'b0110; slip_pos = 0; win_lo = 12; win_hi = 31; clear_stats();
    start_pulse();
    wait_aligned("tap12", 1000);
    chk("tap12_delay_val", int'(delay_val), 12);
    chk("tap12_pulses_t0", pulses_at[0], 3);
    chk("tap12_pulses_t4", pulses_at[4], 3);
    chk("tap12_pulses_t8", pulses_at[8], 3);
    chk("tap12_fail", int'(fail), 0);

    // Eye never open: exhaust taps and stick in FAIL at tap 28
    win_lo = 32; clear_stats();
    start_pulse();
    n = 0;
    while (!fail && n < 2000) begin tick(); n++; end
    chk("never_fail", int'(fail), 1);
    chk("never_busy", int'(busy), 0);
    chk("never_delay_val", int'(delay_val), 28);
    chk("never_pulses", pulse_cnt, 24);
    repeat (20) tick();
    chk("never_no_slip_after_fail", pulse_cnt, 24);
    start_pulse();
    chk("never_restart_delay_val", int'(delay_val), 0);
    chk("never_restart_fail", int'(fail), 0);
    chk("never_restart_busy", int'(busy), 1);

    // Ready drops mid-settle: stays busy, then a full settle precedes checking
    win_lo = 0; base = PAT; slip_pos = 0;
    wait_aligned("rdy_pre", 1000);
    start_pulse();
    repeat (3) tick();
    idelay_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rdy_drop_busy", int'(busy), 1);
    end
    idelay_rdy = 1'b1;
    tick();
    t0 = cyc;
    wait_aligned("rdy_back", 60);
    chk("rdy_back_latency", cyc - t0, 25);

    // Asynchronous reset while the bitslip strobe is high
    base = 4'b0110; slip_pos = 0;
    start_pulse();
    n = 0;
    while (!bitslip && n < 100) begin tick(); n++; end
    chk("arst_in_slip", int'(bitslip), 1);
    rst_n_in = 1'b0;
    #1;
    chk("arst_bitslip", int'(bitslip), 0);
    chk("arst_delay_val", int'(delay_val), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_aligned", int'(aligned), 0);
    chk("arst_slip_cnt", int'(slip_cnt), 0);
    chk("arst_relock_cnt", int'(relock_cnt), 0);
    tick(); tick();
    rst_n_in = 1'b1;
    tick();

    // Randomised training runs against the model
    noise_rand = 1'b1;
    rdy_hold = 0;
    for (int trial = 0; trial < 12; trial++) begin
      base = rotl(PAT, int'($urandom_range(0, 3)));
      win_lo = int'($urandom_range(0, 31));
      win_hi = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(win_lo, 31));
      start_pulse();
      for (int c = 0; c < 700; c++) begin
        start = ($urandom_range(0, 149) == 0);
        if (rdy_hold > 0) rdy_hold--;
        else if ($urandom_range(0, 99) == 0) rdy_hold = int'($urandom_range(1, 12));
        idelay_rdy = (rdy_hold == 0);
        if (inj_left == 0 && $urandom_range(0, 59) == 0) inj_left = int'($urandom_range(1, 5));
        tick();
      end
      start = 1'b0;
      idelay_rdy = 1'b1;
      rdy_hold = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
